tnn_stream_classifier: RTL

Parametrised, feature-serial ternary neural network classifier with valid/ready handshakes on input and output. Weights are compile-time parameters, so one RTL body serves every dataset. Layer 1 processes one feature per cycle across all hidden neurons. Layer 2 processes one hidden neuron per cycle across all classes. A registered argmax produces the class index, held until the consumer accepts it.

---
 rtl/tnn_stream_classifier.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tnn_stream_classifier.sv
// Feature-serial ternary neural network classifier with valid/ready handshakes.
// Optional score_max_o output is built when TNN_SCORE_OUT_EN is defined.
module tnn_stream_classifier #(
    parameter int unsigned FEAT_CNT   = 128,
    parameter int unsigned FEAT_BITS  = 4,
    parameter int unsigned HIDDEN_CNT = 40,
    parameter int unsigned CLASS_CNT  = 6,
    parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_POS = '0,
    parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_NEG = '0,
    parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_POS = '0,
    parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_NEG = '0
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    input  logic [FEAT_BITS*FEAT_CNT-1:0]             data_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [$clog2(CLASS_CNT)-1:0]              prediction_o
`ifdef TNN_SCORE_OUT_EN
    ,
    output logic signed [$clog2(HIDDEN_CNT+1):0]      score_max_o
`endif
);

    localparam int unsigned AccW   = FEAT_BITS + $clog2(FEAT_CNT + 1) + 1;
    localparam int unsigned ScoreW = $clog2(HIDDEN_CNT + 1) + 1;
    localparam int unsigned PredW  = $clog2(CLASS_CNT);
    localparam int unsigned CntMax = (FEAT_CNT > HIDDEN_CNT) ? FEAT_CNT : HIDDEN_CNT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StL1, StL2, StArgmax, StHold} state_e;

    state_e                        state_q, state_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [FEAT_BITS*FEAT_CNT-1:0] data_q, data_d;
    logic signed [AccW-1:0]        acc_q [HIDDEN_CNT];
    logic signed [AccW-1:0]        acc_d [HIDDEN_CNT];
    logic signed [ScoreW-1:0]      score_q [CLASS_CNT];
    logic signed [ScoreW-1:0]      score_d [CLASS_CNT];
    logic [PredW-1:0]              pred_q, pred_d;

    logic [FEAT_BITS-1:0]          feat;
    logic signed [AccW-1:0]        feat_s;
    logic [HIDDEN_CNT-1:0]         w1_pos, w1_neg;
    logic                          hbit;
    logic [CLASS_CNT-1:0]          w2_pos, w2_neg;
    logic signed [ScoreW-1:0]      best_score;
    logic [PredW-1:0]              best_idx;

    // Select the current feature, hidden bit and weight slices addressed by the counter.
    always_comb begin
        feat   = '0;
        hbit   = 1'b0;
        w1_pos = '0;
        w1_neg = '0;
        w2_pos = '0;
        w2_neg = '0;
        for (int unsigned f = 0; f < FEAT_CNT; f++) begin
            if (cnt_q == CntW'(f)) begin
                feat = data_q[f*FEAT_BITS +: FEAT_BITS];
                for (int unsigned h = 0; h < HIDDEN_CNT; h++) begin
                    w1_pos[h] = W1_POS[h*FEAT_CNT + f];
                    w1_neg[h] = W1_NEG[h*FEAT_CNT + f];
                end
            end
        end
        for (int unsigned h = 0; h < HIDDEN_CNT; h++) begin
            if (cnt_q == CntW'(h)) begin
                hbit = ~acc_q[h][AccW-1];
                for (int unsigned c = 0; c < CLASS_CNT; c++) begin
                    w2_pos[c] = W2_POS[c*HIDDEN_CNT + h];
                    w2_neg[c] = W2_NEG[c*HIDDEN_CNT + h];
                end
            end
        end
    end

    assign feat_s = $signed({{(AccW-FEAT_BITS){1'b0}}, feat});

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_score = score_q[0];
        best_idx   = '0;
        for (int unsigned c = 1; c < CLASS_CNT; c++) begin
            if (score_q[c] > best_score) begin
                best_score = score_q[c];
                best_idx   = PredW'(c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        acc_d   = acc_q;
        score_d = score_q;
        pred_d  = pred_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    data_d = data_i;
                    cnt_d  = '0;
                    for (int unsigned h = 0; h < HIDDEN_CNT; h++) acc_d[h] = '0;
                    for (int unsigned c = 0; c < CLASS_CNT; c++) score_d[c] = '0;
                    state_d = StL1;
                end
            end
            StL1: begin
                for (int unsigned h = 0; h < HIDDEN_CNT; h++) begin
                    if (w1_pos[h] && !w1_neg[h]) begin
                        acc_d[h] = acc_q[h] + feat_s;
                    end else if (w1_neg[h] && !w1_pos[h]) begin
                        acc_d[h] = acc_q[h] - feat_s;
                    end
                end
                if (cnt_q == CntW'(FEAT_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = StL2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StL2: begin
                if (hbit) begin
                    for (int unsigned c = 0; c < CLASS_CNT; c++) begin
                        if (w2_pos[c] && !w2_neg[c]) begin
                            score_d[c] = score_q[c] + ScoreW'(1);
                        end else if (w2_neg[c] && !w2_pos[c]) begin
                            score_d[c] = score_q[c] - ScoreW'(1);
                        end
                    end
                end
                if (cnt_q == CntW'(HIDDEN_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = StArgmax;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StArgmax: begin
                pred_d  = best_idx;
                state_d = StHold;
            end
            StHold: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            pred_q  <= '0;
            for (int unsigned h = 0; h < HIDDEN_CNT; h++) acc_q[h] <= '0;
            for (int unsigned c = 0; c < CLASS_CNT; c++) score_q[c] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pred_q  <= pred_d;
            acc_q   <= acc_d;
            score_q <= score_d;
        end
    end

`ifdef TNN_SCORE_OUT_EN
    logic signed [ScoreW-1:0] smax_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smax_q <= '0;
        end else if (state_q == StArgmax) begin
            smax_q <= best_score;
        end
    end

    assign score_max_o = smax_q;
`endif

    assign in_ready_o   = (state_q == StIdle);
    assign out_valid_o  = (state_q == StHold);
    assign prediction_o = pred_q;

endmodule
